// File: rtl/draw_processor_pkg.sv
// Shared constants, instruction field layout and pixel address helpers for the
// draw processor and its shadow framebuffer.
package draw_processor_pkg;

  localparam int SCREEN_W          = 160;
  localparam int SCREEN_H          = 120;
  localparam int X_W               = 8;
  localparam int Y_W               = 7;
  localparam int COL_W             = 3;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int RESULT_WIDTH      = 32;
  localparam int OPCODE_W          = 4;
  localparam int FB_DEPTH          = SCREEN_W * SCREEN_H;
  localparam int ADDR_W            = 15;

  localparam int OPCODE_LSB = 28;
  localparam int PLOT_BIT   = 18;
  localparam int COL_LSB    = 15;
  localparam int Y_LSB      = 8;
  localparam int X_LSB      = 0;

  localparam int ERR_BOUNDS = 31;
  localparam int ERR_OPCODE = 30;

  localparam logic [OPCODE_W-1:0] OP_NOP   = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_PLOT  = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_READ  = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_CLEAR = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_e;

  // y*160 + x via shifts; coordinates past the screen fold back into the RAM.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
    logic [ADDR_W-1:0] raw;
    raw = (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
    return (raw >= ADDR_W'(FB_DEPTH)) ? raw - ADDR_W'(FB_DEPTH) : raw;
  endfunction

  function automatic logic in_bounds(input logic [X_W-1:0] x,
                                     input logic [Y_W-1:0] y);
    return (x < X_W'(SCREEN_W)) && (y < Y_W'(SCREEN_H));
  endfunction

endpackage

// File: rtl/draw_processor_if.sv
// Drawer-to-processor instruction handshake plus the VGA adapter write port.
interface draw_processor_if;
  import draw_processor_pkg::*;

  logic                         start;
  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic                         finished;
  logic [RESULT_WIDTH-1:0]      result;
  logic [X_W-1:0]               vga_x;
  logic [Y_W-1:0]               vga_y;
  logic [COL_W-1:0]             vga_colour;
  logic                         vga_plot;

  modport master (
    output start, instruction,
    input  finished, result, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start, instruction,
    output finished, result, vga_x, vga_y, vga_colour, vga_plot
  );

endinterface

// File: rtl/dp_framebuffer.sv
// Shadow framebuffer: single-port synchronous RAM, one colour per pixel,
// registered read data with a one-cycle latency.
module dp_framebuffer
  import draw_processor_pkg::*;
(
  input  logic              clock,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [COL_W-1:0]  wdata,
  output logic [COL_W-1:0]  rdata
);

  logic [COL_W-1:0] mem [FB_DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; contents survive reset.
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/draw_processor.sv
// Decodes draw instructions, drives the VGA write port and mirrors writes into
// the shadow framebuffer. Define DP_BOUNDS_CHECK_EN to reject off-screen PLOT/READ.
module draw_processor
  import draw_processor_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  draw_processor_if.slave  bus
);

  state_e                 state;
  logic [OPCODE_W-1:0]    op_q;
  logic                   oob_q;

  logic [OPCODE_W-1:0]    in_op;
  logic                   in_plot;
  logic [COL_W-1:0]       in_colour;
  logic [Y_W-1:0]         in_y;
  logic [X_W-1:0]         in_x;
  logic                   in_ok;
  logic                   accept;
  logic                   last_pixel;

  logic                   fb_we;
  logic                   fb_re;
  logic [ADDR_W-1:0]      fb_addr;
  logic [COL_W-1:0]       fb_rdata;
  logic [RESULT_WIDTH-1:0] next_result;

  assign in_op     = bus.instruction[OPCODE_LSB +: OPCODE_W];
  assign in_plot   = bus.instruction[PLOT_BIT];
  assign in_colour = bus.instruction[COL_LSB +: COL_W];
  assign in_y      = bus.instruction[Y_LSB +: Y_W];
  assign in_x      = bus.instruction[X_LSB +: X_W];

`ifdef DP_BOUNDS_CHECK_EN
  assign in_ok = in_bounds(in_x, in_y);
`else
  assign in_ok = 1'b1;
`endif

  assign accept     = (state == ST_IDLE) && bus.start;
  assign last_pixel = (bus.vga_x == X_W'(SCREEN_W - 1)) && (bus.vga_y == Y_W'(SCREEN_H - 1));

  // The read is launched on the accept edge so its data is ready when EXEC
  // completes; every VGA write in EXEC is mirrored at the pixel on the port.
  assign fb_we   = (state == ST_EXEC) && bus.vga_plot;
  assign fb_re   = accept && (in_op == OP_READ) && in_ok;
  assign fb_addr = (state == ST_EXEC) ? pixel_addr(bus.vga_x, bus.vga_y)
                                      : pixel_addr(in_x, in_y);

  dp_framebuffer u_fb (
    .clock (clock),
    .we    (fb_we),
    .re    (fb_re),
    .addr  (fb_addr),
    .wdata (bus.vga_colour),
    .rdata (fb_rdata)
  );

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    next_result = '0;
    case (op_q)
      OP_NOP, OP_CLEAR: ;
      OP_PLOT: next_result[ERR_BOUNDS] = oob_q;
      OP_READ: begin
        if (oob_q) next_result[ERR_BOUNDS] = 1'b1;
        else       next_result[COL_W-1:0]  = fb_rdata;
      end
      default: next_result[ERR_OPCODE] = 1'b1;
    endcase
  end

  // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      op_q           <= OP_NOP;
      oob_q          <= 1'b0;
      bus.finished   <= 1'b1;
      bus.result     <= '0;
      bus.vga_x      <= '0;
      bus.vga_y      <= '0;
      bus.vga_colour <= '0;
      bus.vga_plot   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state        <= ST_EXEC;
            op_q         <= in_op;
            oob_q        <= !in_ok;
            bus.finished <= 1'b0;
            case (in_op)
              OP_PLOT: begin
                bus.vga_x      <= in_x;
                bus.vga_y      <= in_y;
                bus.vga_colour <= in_colour;
                bus.vga_plot   <= in_plot && in_ok;
              end
              OP_CLEAR: begin
                bus.vga_x      <= '0;
                bus.vga_y      <= '0;
                bus.vga_colour <= in_colour;
                bus.vga_plot   <= 1'b1;
              end
              default: ;
            endcase
          end
        end

        ST_EXEC: begin
          if ((op_q == OP_CLEAR) && !last_pixel) begin
            if (bus.vga_x == X_W'(SCREEN_W - 1)) begin
              bus.vga_x <= '0;
              bus.vga_y <= bus.vga_y + 1'b1;
            end else begin
              bus.vga_x <= bus.vga_x + 1'b1;
            end
          end else begin
            state        <= ST_DONE;
            bus.vga_plot <= 1'b0;
            bus.finished <= 1'b1;
            bus.result   <= next_result;
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
